// File: rtl/gf180mcu_ef_io_bi_ctrl.sv
// Controller for a gf180mcu bidirectional pad cell.
// A configuration request walks the pad through a break-before-make sequence:
// output drivers off, then inputs and pulls off for a settle period, then the
// new static controls, then the output enable. The pad input is
// synchronized and debounced into in_data/in_edge.
//
// Handshake: a configuration transfers on a rising clk edge where
// cfg_valid=1 and cfg_ready=1. All cfg_* fields are sampled at that edge.
// cfg_ready is 1 only while the FSM is idle. The requester keeps cfg_valid and
// its fields stable until the transfer happens.
module gf180mcu_ef_io_bi_ctrl #(
  parameter int SETTLE_CYC = 4,
  parameter int DEB_CYC    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_mode,
  input  logic [1:0] cfg_drv,
  input  logic       cfg_sl,
  input  logic       cfg_cs,
  output logic [2:0] cur_mode,
  input  logic       out_data,
  output logic       in_data,
  output logic       in_edge,
  output logic       pad_cs,
  output logic       pad_sl,
  output logic       pad_ie,
  output logic       pad_oe,
  output logic       pad_pu,
  output logic       pad_pd,
  output logic       pad_a,
  output logic       pad_pdrv0,
  output logic       pad_pdrv1,
  input  logic       pad_y,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DRAIN  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] APPLY  = 3'd3;
  localparam logic [2:0] ENABLE = 3'd4;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] DEB_LAST    = 4'(DEB_CYC - 1);

  logic [2:0] state;
  logic [3:0] settle_cnt;
  logic [2:0] cap_mode;
  logic [1:0] cap_drv;
  logic       cap_sl;
  logic       cap_cs;
  logic       mode_ie;
  logic       mode_oe;

  logic       sync1;
  logic       sync2;
  logic [3:0] deb_cnt;

  assign cfg_ready = (state == IDLE);
  assign dbg_state = state;

  // Decode which enables the captured mode asks for.
  always_comb begin
    mode_ie = 1'b0;
    mode_oe = 1'b0;
    case (cap_mode)
      3'd1, 3'd2, 3'd3: mode_ie = 1'b1;
      3'd4:             mode_oe = 1'b1;
      3'd5: begin
        mode_ie = 1'b1;
        mode_oe = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer: each transition also loads the pad controls of the state entered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      settle_cnt <= 4'd0;
      cap_mode   <= 3'd0;
      cap_drv    <= 2'd0;
      cap_sl     <= 1'b0;
      cap_cs     <= 1'b0;
      cur_mode   <= 3'd0;
      pad_cs     <= 1'b0;
      pad_sl     <= 1'b0;
      pad_ie     <= 1'b0;
      pad_oe     <= 1'b0;
      pad_pu     <= 1'b0;
      pad_pd     <= 1'b0;
      pad_pdrv0  <= 1'b0;
      pad_pdrv1  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            // Reserved modes collapse to disabled at capture.
            cap_mode <= (cfg_mode > 3'd5) ? 3'd0 : cfg_mode;
            cap_drv  <= cfg_drv;
            cap_sl   <= cfg_sl;
            cap_cs   <= cfg_cs;
            pad_oe   <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          pad_ie     <= 1'b0;
          pad_pu     <= 1'b0;
          pad_pd     <= 1'b0;
          settle_cnt <= 4'd0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
            pad_sl     <= cap_sl;
            pad_cs     <= cap_cs;
            pad_pdrv1  <= cap_drv[1];
            pad_pdrv0  <= cap_drv[0];
            pad_ie     <= mode_ie;
            pad_pu     <= (cap_mode == 3'd2);
            pad_pd     <= (cap_mode == 3'd3);
            state      <= APPLY;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        APPLY: begin
          pad_oe   <= mode_oe;
          cur_mode <= cap_mode;
          state    <= ENABLE;
        end
        ENABLE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output data path is a plain register, independent of the sequencer.
  always_ff @(posedge clk) begin
    if (!reset_n) pad_a <= 1'b0;
    else          pad_a <= out_data;
  end

  // Input path: two-flop synchronizer followed by a debounce counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb_cnt <= 4'd0;
      in_data <= 1'b0;
      in_edge <= 1'b0;
    end else begin
      sync1   <= pad_y;
      sync2   <= sync1;
      in_edge <= 1'b0;
      if (!pad_ie || (sync2 == in_data)) begin
        deb_cnt <= 4'd0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt <= 4'd0;
        in_data <= sync2;
        in_edge <= 1'b1;
      end else begin
        deb_cnt <= deb_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_gf180mcu_ef_io_bi_ctrl.sv
// Directed bench for gf180mcu_ef_io_bi_ctrl (SETTLE_CYC=4, DEB_CYC=3).
// Timing reference: after each rising edge the bench waits #1, then drives
// inputs and samples outputs. "i" counts edges after the accept edge.
module tb_gf180mcu_ef_io_bi_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_mode = 3'd0;
  logic [1:0] cfg_drv = 2'd0;
  logic       cfg_sl = 1'b0;
  logic       cfg_cs = 1'b0;
  logic [2:0] cur_mode;
  logic       out_data = 1'b0;
  logic       in_data;
  logic       in_edge;
  logic       pad_cs, pad_sl, pad_ie, pad_oe, pad_pu, pad_pd, pad_a;
  logic       pad_pdrv0, pad_pdrv1;
  logic       pad_y = 1'b0;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  gf180mcu_ef_io_bi_ctrl #(.SETTLE_CYC(4), .DEB_CYC(3)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_drv(cfg_drv), .cfg_sl(cfg_sl), .cfg_cs(cfg_cs),
    .cur_mode(cur_mode), .out_data(out_data), .in_data(in_data), .in_edge(in_edge),
    .pad_cs(pad_cs), .pad_sl(pad_sl), .pad_ie(pad_ie), .pad_oe(pad_oe),
    .pad_pu(pad_pu), .pad_pd(pad_pd), .pad_a(pad_a), .pad_pdrv0(pad_pdrv0),
    .pad_pdrv1(pad_pdrv1), .pad_y(pad_y), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request, wait (bounded) for ready, pass the accept edge, drop valid.
  task automatic accept(input logic [2:0] m, input logic [1:0] d, input logic sl, input logic cs);
    int t;
    t = 0;
    cfg_mode = m; cfg_drv = d; cfg_sl = sl; cfg_cs = cs; cfg_valid = 1'b1;
    while (!cfg_ready && t < 50) begin
      tick();
      t++;
    end
    n_tests++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_wait: cfg_ready=%b after %0d cycles, required 1", cfg_ready, t);
    end
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    n_tests++;
    if ({pad_cs, pad_sl, pad_ie, pad_oe, pad_pu, pad_pd, pad_a, pad_pdrv0, pad_pdrv1} !== 9'b0) begin
      n_fail++; $display("FAIL reset_pads: got %b required 000000000",
        {pad_cs, pad_sl, pad_ie, pad_oe, pad_pu, pad_pd, pad_a, pad_pdrv0, pad_pdrv1});
    end
    n_tests++;
    if ({cfg_ready, cur_mode, in_data, in_edge, dbg_state} !== {1'b1, 3'd0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++; $display("FAIL reset_status: ready/mode/in/edge/state=%b/%0d/%b/%b/%0d required 1/0/0/0/0",
        cfg_ready, cur_mode, in_data, in_edge, dbg_state);
    end
  endtask

  task automatic test_output();
    out_data = 1'b1;
    accept(3'd4, 2'b11, 1'b0, 1'b0);
    n_tests++;
    if ({dbg_state, pad_oe, cfg_ready} !== {3'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL out_drain: state/oe/ready=%0d/%b/%b required 1/0/0", dbg_state, pad_oe, cfg_ready);
    end
    for (int i = 1; i <= 7; i++) begin
      tick();
      n_tests++;
      if (cfg_ready !== (i == 7)) begin
        n_fail++; $display("FAIL out_latency: i=%0d cfg_ready=%b required %b", i, cfg_ready, (i == 7));
      end
    end
    n_tests++;
    if ({pad_oe, pad_pdrv1, pad_pdrv0, pad_a, pad_ie, pad_pu, pad_pd, cur_mode} !== {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4}) begin
      n_fail++; $display("FAIL out_final: oe/drv/a/ie/pu/pd/mode=%b/%b%b/%b/%b/%b/%b/%0d required 1/11/1/0/0/0/4",
        pad_oe, pad_pdrv1, pad_pdrv0, pad_a, pad_ie, pad_pu, pad_pd, cur_mode);
    end
    // Input enable is off in output mode: pad activity must not reach in_data.
    pad_y = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if ({in_data, in_edge} !== 2'b00) begin
        n_fail++; $display("FAIL ie_gate: k=%0d in/edge=%b%b required 00", k, in_data, in_edge);
      end
    end
    pad_y = 1'b0;
    tick(4);
  endtask

  task automatic test_mode_change();
    accept(3'd2, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i <= 7; i++) begin
      if (i > 0) tick();
      n_tests++;
      if (pad_oe !== 1'b0 || (pad_pu && pad_pd) !== 1'b0) begin
        n_fail++; $display("FAIL chg_safe: i=%0d oe/pu/pd=%b/%b/%b required oe=0, not pu&pd", i, pad_oe, pad_pu, pad_pd);
      end
      if (i >= 1 && i <= 4) begin
        n_tests++;
        if ({pad_ie, pad_pu, pad_pd, pad_oe, pad_pdrv1, pad_pdrv0} !== 6'b000011) begin
          n_fail++; $display("FAIL chg_settle: i=%0d ie/pu/pd/oe/drv=%b required 000011", i,
            {pad_ie, pad_pu, pad_pd, pad_oe, pad_pdrv1, pad_pdrv0});
        end
      end
      if (i == 5) begin
        n_tests++;
        if ({pad_ie, pad_pu, pad_pd, pad_pdrv1, pad_pdrv0} !== 5'b11000) begin
          n_fail++; $display("FAIL chg_apply: ie/pu/pd/drv=%b required 11000",
            {pad_ie, pad_pu, pad_pd, pad_pdrv1, pad_pdrv0});
        end
      end
    end
    n_tests++;
    if ({cfg_ready, cur_mode} !== {1'b1, 3'd2}) begin
      n_fail++; $display("FAIL chg_final: ready/mode=%b/%0d required 1/2", cfg_ready, cur_mode);
    end
  endtask

  task automatic test_input();
    accept(3'd1, 2'b00, 1'b0, 1'b1);
    tick(7);
    n_tests++;
    if ({cfg_ready, cur_mode, pad_ie, pad_pu, pad_pd, pad_cs} !== {1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL in_cfg: ready/mode/ie/pu/pd/cs=%b/%0d/%b/%b/%b/%b required 1/1/1/0/0/1",
        cfg_ready, cur_mode, pad_ie, pad_pu, pad_pd, pad_cs);
    end
    // Rising input: visible on the 5th edge after the change (2 sync + 3 debounce).
    pad_y = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_tests++;
      if ({in_data, in_edge} !== {(k >= 5), (k == 5)}) begin
        n_fail++; $display("FAIL in_rise: k=%0d in/edge=%b%b required %b%b", k, in_data, in_edge, (k >= 5), (k == 5));
      end
    end
    // Two-cycle low glitch is filtered.
    pad_y = 1'b0;
    tick(2);
    pad_y = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if ({in_data, in_edge} !== 2'b10) begin
        n_fail++; $display("FAIL in_glitch: k=%0d in/edge=%b%b required 10", k, in_data, in_edge);
      end
    end
    // Held falling input.
    pad_y = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_tests++;
      if ({in_data, in_edge} !== {(k < 5), (k == 5)}) begin
        n_fail++; $display("FAIL in_fall: k=%0d in/edge=%b%b required %b%b", k, in_data, in_edge, (k < 5), (k == 5));
      end
    end
  endtask

  task automatic test_busy_hold();
    accept(3'd4, 2'b01, 1'b1, 1'b1);
    tick(2);
    cfg_mode = 3'd3; cfg_drv = 2'b10; cfg_sl = 1'b0; cfg_cs = 1'b0; cfg_valid = 1'b1;
    for (int i = 3; i <= 7; i++) begin
      tick();
      n_tests++;
      if (cfg_ready !== (i == 7)) begin
        n_fail++; $display("FAIL busy_ready: i=%0d cfg_ready=%b required %b", i, cfg_ready, (i == 7));
      end
    end
    n_tests++;
    if ({cur_mode, pad_oe, pad_pdrv1, pad_pdrv0, pad_sl, pad_cs, pad_pu, pad_pd} !== {3'd4, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL busy_first: mode/oe/drv/sl/cs/pu/pd=%0d/%b/%b%b/%b/%b/%b/%b required 4/1/01/1/1/0/0",
        cur_mode, pad_oe, pad_pdrv1, pad_pdrv0, pad_sl, pad_cs, pad_pu, pad_pd);
    end
    tick();
    cfg_valid = 1'b0;
    n_tests++;
    if ({dbg_state, cfg_ready, pad_oe} !== {3'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL busy_accept: state/ready/oe=%0d/%b/%b required 1/0/0", dbg_state, cfg_ready, pad_oe);
    end
    tick(7);
    n_tests++;
    if ({cfg_ready, cur_mode, pad_pd, pad_pu, pad_ie, pad_oe, pad_pdrv1, pad_pdrv0, pad_sl, pad_cs}
        !== {1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL busy_second: ready/mode/pd/pu/ie/oe/drv/sl/cs=%b/%0d/%b/%b/%b/%b/%b%b/%b/%b required 1/3/1/0/1/0/10/0/0",
        cfg_ready, cur_mode, pad_pd, pad_pu, pad_ie, pad_oe, pad_pdrv1, pad_pdrv0, pad_sl, pad_cs);
    end
  endtask

  task automatic test_reset_mid();
    accept(3'd5, 2'b00, 1'b0, 1'b0);
    tick(3);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_tests++;
    if ({pad_cs, pad_sl, pad_ie, pad_oe, pad_pu, pad_pd, pad_a, pad_pdrv0, pad_pdrv1, cur_mode, cfg_ready}
        !== {9'b0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL rstmid_state: pads=%b mode=%0d ready=%b required 000000000/0/1",
        {pad_cs, pad_sl, pad_ie, pad_oe, pad_pu, pad_pd, pad_a, pad_pdrv0, pad_pdrv1}, cur_mode, cfg_ready);
    end
    accept(3'd5, 2'b10, 1'b1, 1'b0);
    tick(7);
    n_tests++;
    if ({cfg_ready, cur_mode, pad_oe, pad_ie, pad_pu, pad_pd, pad_pdrv1, pad_pdrv0, pad_sl, pad_a}
        !== {1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rstmid_bidir: ready/mode/oe/ie/pu/pd/drv/sl/a=%b/%0d/%b/%b/%b/%b/%b%b/%b/%b required 1/5/1/1/0/0/10/1/1",
        cfg_ready, cur_mode, pad_oe, pad_ie, pad_pu, pad_pd, pad_pdrv1, pad_pdrv0, pad_sl, pad_a);
    end
  endtask

  task automatic test_back_to_back();
    accept(3'd5, 2'b10, 1'b1, 1'b0);
    n_tests++;
    if ({pad_oe, pad_ie, cfg_ready} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_drain: oe/ie/ready=%b required 010", {pad_oe, pad_ie, cfg_ready});
    end
    tick(2);
    n_tests++;
    if ({pad_oe, pad_ie} !== 2'b00) begin
      n_fail++; $display("FAIL b2b_settle: oe/ie=%b required 00", {pad_oe, pad_ie});
    end
    tick(4);
    n_tests++;
    if ({cfg_ready, pad_oe, pad_ie} !== 3'b011) begin
      n_fail++; $display("FAIL b2b_enable: ready/oe/ie=%b required 011", {cfg_ready, pad_oe, pad_ie});
    end
    tick();
    n_tests++;
    if ({cfg_ready, cur_mode} !== {1'b1, 3'd5}) begin
      n_fail++; $display("FAIL b2b_final: ready/mode=%b/%0d required 1/5", cfg_ready, cur_mode);
    end
  endtask

  task automatic test_reserved();
    accept(3'd7, 2'b01, 1'b0, 1'b0);
    tick(7);
    n_tests++;
    if ({cfg_ready, cur_mode, pad_ie, pad_oe, pad_pu, pad_pd} !== {1'b1, 3'd0, 4'b0000}) begin
      n_fail++; $display("FAIL reserved: ready/mode/ie/oe/pu/pd=%b/%0d/%b/%b/%b/%b required 1/0/0/0/0/0",
        cfg_ready, cur_mode, pad_ie, pad_oe, pad_pu, pad_pd);
    end
  endtask

  // Sequence and final report
  initial begin
    tick();
    test_reset();
    test_output();
    test_mode_change();
    test_input();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back();
    test_reserved();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
